// File: rtl/axis_wrap_rr_mux_pkg.sv
// Shared types for the packet-aware wrap-stream round-robin mux.
// Beat struct widths track the default mux parameters below.
package l3l4cs_axis_wrap_pkg;

    localparam int WRAP_WORDS  = 8;
    localparam int WRAP_DATA   = 32;
    localparam int WRAP_ADDR   = 16;
    localparam int WRAP_VALID  = 4;
    localparam int WRAP_MRK_WD = 31;
    localparam int WRAP_CNT_WD = 16;

    typedef struct packed {
        logic [WRAP_WORDS*WRAP_DATA-1:0] data;
        logic [WRAP_ADDR-1:0]            addr;
        logic [WRAP_VALID-1:0]           vld;
        logic [WRAP_MRK_WD-1:0]          mrk;
        logic                            sop;
        logic                            eop;
    } wrap_beat_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } mux_state_e;

endpackage

// File: rtl/axis_wrap_rr_arb.sv
// Combinational CH-way round-robin arbiter: grants the first requester
// strictly after ptr, wrapping circularly.
module axis_wrap_rr_arb #(
    parameter int CH = 4
) (
    input  logic [CH-1:0]         req,
    input  logic [$clog2(CH)-1:0] ptr,
    output logic [CH-1:0]         gnt,
    output logic [$clog2(CH)-1:0] gnt_idx,
    output logic                  gnt_any
);
    localparam int CHW = $clog2(CH);

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        // Walk from the farthest offset inward so the nearest requester wins.
        for (int off = CH; off >= 1; off--) begin
            idx = (int'(ptr) + off) % CH;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = CHW'(idx);
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_wrap_rr_mux.sv
// Packet-aware round-robin mux: a granted channel owns the output from its
// first beat through its eop beat; the output register gives 1-cycle latency.
module axis_wrap_rr_mux
    import l3l4cs_axis_wrap_pkg::*;
#(
    parameter int CH     = 4,
    parameter int WORDS  = WRAP_WORDS,
    parameter int DATA   = WRAP_DATA,
    parameter int ADDR   = WRAP_ADDR,
    parameter int VALID  = WRAP_VALID,
    parameter int MRK_WD = WRAP_MRK_WD,
    parameter int CNT_WD = WRAP_CNT_WD
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CH-1:0]             cfg_ch_en,
    input  logic [CH-1:0]             s_valid,
    output logic [CH-1:0]             s_ready,
    input  logic [CH*WORDS*DATA-1:0]  s_data,
    input  logic [CH*ADDR-1:0]        s_addr,
    input  logic [CH*VALID-1:0]       s_vld,
    input  logic [CH*MRK_WD-1:0]      s_mrk,
    input  logic [CH-1:0]             s_sop,
    input  logic [CH-1:0]             s_eop,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [WORDS*DATA-1:0]     m_data,
    output logic [ADDR-1:0]           m_addr,
    output logic [VALID-1:0]          m_vld,
    output logic [MRK_WD-1:0]         m_mrk,
    output logic                      m_sop,
    output logic                      m_eop,
    output logic [$clog2(CH)-1:0]     m_ch,
    output logic [CNT_WD-1:0]         pkt_cnt,
    output logic                      err
);
    localparam int CHW = $clog2(CH);
    localparam int BW  = WORDS * DATA;

    mux_state_e      state_q, state_d;
    logic [CH-1:0]   grant_oh_q, grant_oh_d;
    logic [CHW-1:0]  grant_q, grant_d;
    logic [CHW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            first_q, first_d;
    logic            m_valid_q, m_valid_d;
    wrap_beat_t      beat_q, beat_d;
    logic [CHW-1:0]  m_ch_q, m_ch_d;
    logic [CNT_WD-1:0] pkt_cnt_q, pkt_cnt_d;
    logic            err_q, err_d;

    logic [CH-1:0]   arb_gnt;
    logic [CHW-1:0]  arb_idx;
    logic            arb_any;
    wrap_beat_t      sel;
    logic            out_rdy, accept, bad_beat;

    axis_wrap_rr_arb #(.CH(CH)) u_arb (
        .req     (s_valid & cfg_ch_en),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    always_comb begin
        sel.data = s_data[int'(grant_q)*BW +: BW];
        sel.addr = s_addr[int'(grant_q)*ADDR +: ADDR];
        sel.vld  = s_vld[int'(grant_q)*VALID +: VALID];
        sel.mrk  = s_mrk[int'(grant_q)*MRK_WD +: MRK_WD];
        sel.sop  = s_sop[grant_q];
        sel.eop  = s_eop[grant_q];
    end

    assign out_rdy  = !m_valid_q || m_ready;
    assign s_ready  = (state_q == ST_LOCK) ? (grant_oh_q & {CH{out_rdy}}) : '0;
    assign accept   = |(s_valid & s_ready);
    // A packet's first beat must carry sop and no later beat may; vld must be 1..WORDS.
    assign bad_beat = (first_q != sel.sop) || (sel.vld == '0) || (int'(sel.vld) > WORDS);

    always_comb begin
        state_d    = state_q;
        grant_oh_d = grant_oh_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        first_d    = first_q;
        m_valid_d  = m_valid_q;
        beat_d     = beat_q;
        m_ch_d     = m_ch_q;
        pkt_cnt_d  = pkt_cnt_q;
        err_d      = 1'b0;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
            if (beat_q.eop) pkt_cnt_d = pkt_cnt_q + CNT_WD'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_oh_d = arb_gnt;
                    grant_d    = arb_idx;
                    rr_ptr_d   = arb_idx;
                    first_d    = 1'b1;
                    state_d    = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (accept) begin
                    beat_d    = sel;
                    m_ch_d    = grant_q;
                    m_valid_d = 1'b1;
                    first_d   = 1'b0;
                    err_d     = bad_beat;
                    if (sel.eop) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            grant_oh_q <= '0;
            grant_q    <= '0;
            rr_ptr_q   <= CHW'(CH - 1);
            first_q    <= 1'b0;
            m_valid_q  <= 1'b0;
            beat_q     <= '0;
            m_ch_q     <= '0;
            pkt_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_oh_q <= grant_oh_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            first_q    <= first_d;
            m_valid_q  <= m_valid_d;
            beat_q     <= beat_d;
            m_ch_q     <= m_ch_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_q      <= err_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = beat_q.data;
    assign m_addr  = beat_q.addr;
    assign m_vld   = beat_q.vld;
    assign m_mrk   = beat_q.mrk;
    assign m_sop   = beat_q.sop;
    assign m_eop   = beat_q.eop;
    assign m_ch    = m_ch_q;
    assign pkt_cnt = pkt_cnt_q;
    assign err     = err_q;

endmodule

// File: tb/tb_axis_wrap_rr_mux.sv
// Directed bench for axis_wrap_rr_mux: per-cycle vector table plus
// hand sequences for backpressure and mid-packet reset.
module tb_axis_wrap_rr_mux;

    localparam int CH = 4, WORDS = 8, DATA = 32, ADDR = 16, VALID = 4, MRK_WD = 31, CNT_WD = 16;
    localparam int BW = WORDS * DATA;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic [CH-1:0]            cfg_ch_en = '0;
    logic [CH-1:0]            s_valid = '0;
    logic [CH-1:0]            s_ready;
    logic [CH*BW-1:0]         s_data = '0;
    logic [CH*ADDR-1:0]       s_addr = '0;
    logic [CH*VALID-1:0]      s_vld = '0;
    logic [CH*MRK_WD-1:0]     s_mrk = '0;
    logic [CH-1:0]            s_sop = '0;
    logic [CH-1:0]            s_eop = '0;
    logic                     m_valid;
    logic                     m_ready = 1'b0;
    logic [BW-1:0]            m_data;
    logic [ADDR-1:0]          m_addr;
    logic [VALID-1:0]         m_vld;
    logic [MRK_WD-1:0]        m_mrk;
    logic                     m_sop, m_eop;
    logic [1:0]               m_ch;
    logic [CNT_WD-1:0]        pkt_cnt;
    logic                     err;

    axis_wrap_rr_mux #(.CH(CH), .WORDS(WORDS), .DATA(DATA), .ADDR(ADDR), .VALID(VALID),
                       .MRK_WD(MRK_WD), .CNT_WD(CNT_WD)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_ch_en(cfg_ch_en),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_addr(s_addr),
        .s_vld(s_vld), .s_mrk(s_mrk), .s_sop(s_sop), .s_eop(s_eop),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_addr(m_addr),
        .m_vld(m_vld), .m_mrk(m_mrk), .m_sop(m_sop), .m_eop(m_eop),
        .m_ch(m_ch), .pkt_cnt(pkt_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs for one cycle, then the outputs expected at that cycle's negedge.
    typedef struct {
        bit       rst;
        bit [3:0] en, valid, sop, eop, vld;
        bit       mrdy;
        bit [3:0] x_sready;
        bit       x_mvalid;
        bit [1:0] x_ch;
        bit       x_sop, x_eop;
        bit [3:0] x_vld;
        int       x_pkt;
        bit       x_err;
    } vec_t;

    vec_t tbl[$];

    task automatic do_reset();
        reset_n   = 1'b0;
        s_valid   = '0;
        s_sop     = '0;
        s_eop     = '0;
        s_data    = '0;
        s_addr    = '0;
        s_vld     = '0;
        m_ready   = 1'b0;
        cfg_ch_en = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst m_valid", m_valid, 0);
        chk("rst s_ready", s_ready, 0);
        chk("rst pkt_cnt", pkt_cnt, 0);
        chk("rst err", err, 0);
        chk("rst m_data", m_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input int i, input vec_t v);
        if (v.rst) do_reset();
        cfg_ch_en = v.en;
        s_valid   = v.valid;
        s_sop     = v.sop;
        s_eop     = v.eop;
        s_vld     = {CH{v.vld}};
        m_ready   = v.mrdy;
        @(negedge clk);
        chk($sformatf("v%0d s_ready", i), s_ready, v.x_sready);
        chk($sformatf("v%0d m_valid", i), m_valid, v.x_mvalid);
        chk($sformatf("v%0d pkt_cnt", i), pkt_cnt, v.x_pkt);
        chk($sformatf("v%0d err", i), err, v.x_err);
        if (v.x_mvalid) begin
            chk($sformatf("v%0d m_ch", i), m_ch, v.x_ch);
            chk($sformatf("v%0d m_sop", i), m_sop, v.x_sop);
            chk($sformatf("v%0d m_eop", i), m_eop, v.x_eop);
            chk($sformatf("v%0d m_vld", i), m_vld, v.x_vld);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ch1(input int k);
        s_valid = (k < 4) ? 4'b0010 : 4'b0000;
        s_sop   = (k == 0) ? 4'b0010 : 4'b0000;
        s_eop   = (k == 3) ? 4'b0010 : 4'b0000;
        s_vld   = {CH{4'd8}};
        s_data[BW +: BW]     = {WORDS{32'hC0DE_0000 + 32'(k)}};
        s_addr[ADDR +: ADDR] = 16'(k);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, got, cyc;
        bit locked, locked_n, held, in_x;
        logic [BW-1:0]   sv_data;
        logic [ADDR-1:0] sv_addr;
        bit [3:0] pat;

        // rst en valid sop eop vld mrdy | sready mvalid ch sop eop vld pkt err
        // ch0 3-beat packet: 1 arbitration cycle, then 3 beats, pkt_cnt=1
        tbl.push_back('{1,4'hF,4'b0001,4'b0001,4'b0000,4'd8,1, 4'b0000,0,0,0,0,4'd8,0,0});
        tbl.push_back('{0,4'hF,4'b0001,4'b0001,4'b0000,4'd8,1, 4'b0001,0,0,0,0,4'd8,0,0});
        tbl.push_back('{0,4'hF,4'b0001,4'b0000,4'b0000,4'd8,1, 4'b0001,1,0,1,0,4'd8,0,0});
        tbl.push_back('{0,4'hF,4'b0001,4'b0000,4'b0001,4'd8,1, 4'b0001,1,0,0,0,4'd8,0,0});
        tbl.push_back('{0,4'hF,4'b0000,4'b0000,4'b0000,4'd8,1, 4'b0000,1,0,0,1,4'd8,0,0});
        tbl.push_back('{0,4'hF,4'b0000,4'b0000,4'b0000,4'd8,1, 4'b0000,0,0,0,0,4'd8,1,0});
        // all channels with 1-beat packets: order 0,1,2,3,0
        tbl.push_back('{1,4'hF,4'hF,4'hF,4'hF,4'd8,1, 4'b0000,0,0,0,0,4'd8,0,0});
        tbl.push_back('{0,4'hF,4'hF,4'hF,4'hF,4'd8,1, 4'b0001,0,0,0,0,4'd8,0,0});
        tbl.push_back('{0,4'hF,4'hF,4'hF,4'hF,4'd8,1, 4'b0000,1,0,1,1,4'd8,0,0});
        tbl.push_back('{0,4'hF,4'hF,4'hF,4'hF,4'd8,1, 4'b0010,0,0,0,0,4'd8,1,0});
        tbl.push_back('{0,4'hF,4'hF,4'hF,4'hF,4'd8,1, 4'b0000,1,1,1,1,4'd8,1,0});
        tbl.push_back('{0,4'hF,4'hF,4'hF,4'hF,4'd8,1, 4'b0100,0,0,0,0,4'd8,2,0});
        tbl.push_back('{0,4'hF,4'hF,4'hF,4'hF,4'd8,1, 4'b0000,1,2,1,1,4'd8,2,0});
        tbl.push_back('{0,4'hF,4'hF,4'hF,4'hF,4'd8,1, 4'b1000,0,0,0,0,4'd8,3,0});
        tbl.push_back('{0,4'hF,4'hF,4'hF,4'hF,4'd8,1, 4'b0000,1,3,1,1,4'd8,3,0});
        tbl.push_back('{0,4'hF,4'hF,4'hF,4'hF,4'd8,1, 4'b0001,0,0,0,0,4'd8,4,0});
        tbl.push_back('{0,4'hF,4'h0,4'h0,4'h0,4'd8,1, 4'b0000,1,0,1,1,4'd8,4,0});
        tbl.push_back('{0,4'hF,4'h0,4'h0,4'h0,4'd8,1, 4'b0000,0,0,0,0,4'd8,5,0});
        // ch1 disabled; ch0 enable cleared mid-packet still completes
        tbl.push_back('{1,4'hD,4'b0010,4'b0010,4'b0010,4'd8,1, 4'b0000,0,0,0,0,4'd8,0,0});
        tbl.push_back('{0,4'hD,4'b0010,4'b0010,4'b0010,4'd8,1, 4'b0000,0,0,0,0,4'd8,0,0});
        tbl.push_back('{0,4'hD,4'b0010,4'b0010,4'b0010,4'd8,1, 4'b0000,0,0,0,0,4'd8,0,0});
        tbl.push_back('{0,4'hD,4'b0011,4'b0011,4'b0010,4'd8,1, 4'b0000,0,0,0,0,4'd8,0,0});
        tbl.push_back('{0,4'hC,4'b0011,4'b0011,4'b0010,4'd8,1, 4'b0001,0,0,0,0,4'd8,0,0});
        tbl.push_back('{0,4'hC,4'b0011,4'b0010,4'b0011,4'd8,1, 4'b0001,1,0,1,0,4'd8,0,0});
        tbl.push_back('{0,4'hC,4'b0010,4'b0010,4'b0010,4'd8,1, 4'b0000,1,0,0,1,4'd8,0,0});
        tbl.push_back('{0,4'hC,4'b0010,4'b0010,4'b0010,4'd8,1, 4'b0000,0,0,0,0,4'd8,1,0});
        // protocol errors on ch2: no sop, vld=0, stray sop, vld=9; beats forwarded
        tbl.push_back('{1,4'hF,4'b0100,4'b0000,4'b0000,4'd8,1, 4'b0000,0,0,0,0,4'd8,0,0});
        tbl.push_back('{0,4'hF,4'b0100,4'b0000,4'b0000,4'd8,1, 4'b0100,0,0,0,0,4'd8,0,0});
        tbl.push_back('{0,4'hF,4'b0100,4'b0000,4'b0000,4'd0,1, 4'b0100,1,2,0,0,4'd8,0,1});
        tbl.push_back('{0,4'hF,4'b0100,4'b0100,4'b0000,4'd8,1, 4'b0100,1,2,0,0,4'd0,0,1});
        tbl.push_back('{0,4'hF,4'b0100,4'b0000,4'b0000,4'd9,1, 4'b0100,1,2,1,0,4'd8,0,1});
        tbl.push_back('{0,4'hF,4'b0100,4'b0000,4'b0100,4'd8,1, 4'b0100,1,2,0,0,4'd9,0,1});
        tbl.push_back('{0,4'hF,4'b0000,4'b0000,4'b0000,4'd8,1, 4'b0000,1,2,0,1,4'd8,0,0});
        tbl.push_back('{0,4'hF,4'b0000,4'b0000,4'b0000,4'd8,1, 4'b0000,0,0,0,0,4'd8,1,0});

        foreach (tbl[i]) apply_vec(i, tbl[i]);

        // ch1 4-beat packet under m_ready pattern 1,0,0,1
        do_reset();
        cfg_ch_en = 4'hF;
        pat = 4'b1001;
        k = 0; got = 0; cyc = 0; locked = 0; held = 0;
        sv_data = '0; sv_addr = '0;
        drive_ch1(k);
        m_ready = pat[0];
        while (cyc < 40 && !(got == 4 && m_valid == 1'b0)) begin
            @(negedge clk);
            chk("t3 s_ready1", s_ready[1], locked ? (!m_valid || m_ready) : 1'b0);
            chk("t3 s_ready others", {s_ready[3:2], s_ready[0]}, 0);
            if (held) begin
                chk("t3 held data", m_data, sv_data);
                chk("t3 held addr", m_addr, sv_addr);
            end
            if (m_valid && m_ready) begin
                chk("t3 beat addr", m_addr, got);
                chk("t3 beat data", m_data, {WORDS{32'hC0DE_0000 + 32'(got)}});
                got++;
            end
            held    = m_valid && !m_ready;
            sv_data = m_data;
            sv_addr = m_addr;
            in_x    = s_valid[1] && s_ready[1];
            locked_n = locked ? !(in_x && k == 3) : (k < 4);
            @(posedge clk);
            #1;
            locked = locked_n;
            if (in_x) k++;
            drive_ch1(k);
            cyc++;
            m_ready = pat[cyc % 4];
        end
        chk("t3 beats out", got, 4);
        chk("t3 beats in", k, 4);
        chk("t3 pkt_cnt", pkt_cnt, 1);

        // async reset with a beat held in the output register
        s_data = '0; s_addr = '0;
        s_valid = 4'b0100; s_sop = 4'b0100; s_eop = 4'b0000; m_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6 m_valid before", m_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6 m_valid in rst", m_valid, 0);
        chk("t6 pkt_cnt in rst", pkt_cnt, 0);
        chk("t6 s_ready in rst", s_ready, 0);
        chk("t6 m_sop in rst", m_sop, 0);
        @(negedge clk);
        reset_n = 1'b1;
        s_valid = 4'b0101; s_sop = 4'b0101; s_eop = 4'b0101; m_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6 first grant", s_ready, 4'b0001);
        @(posedge clk); #1;
        s_valid = 4'b0000;
        @(negedge clk);
        chk("t6 m_valid", m_valid, 1);
        chk("t6 m_ch", m_ch, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
